id_control_stage: RTL and testbench
===================================

# id_control_stage

Registered instruction-decode control stage of the pipelined RISC-V core. Accepts one fetched instruction per cycle from IF/ID, decodes the opcode into the main control bundle (ALUop, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite, Branch), generates the immediate, and registers everything into ID/EX. It is the producer of the ALUop/funct7/funct3 triple that the ALU control decodes in EX. It also detects load-use hazards and handles flushes.

## Interface
Parameters:
- XLEN, 64, datapath width for immediate and PC.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  IF/ID holds a valid instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- instr  in  32  instruction word.
- pc_in  in  XLEN  PC of instr.
- flush  in  1  branch taken in EX: discard the current input and the output register.
- out_valid  out  1  ID/EX holds a real instruction (0 = bubble).
- ALUop  out  2  00 add (load/store), 01 branch compare, 10 funct-decoded.
- funct7  out  7  instr[31:25], forced to 0000000 for I-type ALU except funct3=101.
- funct3  out  3  instr[14:12].
- ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite, Branch  out  1 each  main control.
- rs1, rs2, rd  out  5 each  register indices.
- imm  out  XLEN  sign-extended immediate.
- pc_out  out  XLEN  registered pc_in.

## Operation
- Decode per opcode instr[6:0]:
  - 0110011 R: ALUop=10, RegWrite=1, all others 0.
  - 0010011 I-ALU: ALUop=10, ALUSrc=1, RegWrite=1; funct7=0000000 unless funct3=101, then {instr[31:25]} kept (SRLI/SRAI). imm = I-type.
  - 0000011 load: ALUop=00, ALUSrc=1, MemRead=1, MemtoReg=1, RegWrite=1; imm I-type.
  - 0100011 store: ALUop=00, ALUSrc=1, MemWrite=1; imm S-type.
  - 1100011 branch: ALUop=01, Branch=1; imm B-type (bit0=0).
  - any other opcode: decoded as bubble (all controls 0, out_valid=0).
- Immediates sign-extended from instr[31] to XLEN.
- Load-use hazard: registered stage holds out_valid=1 and MemRead=1 and rd!=0, and rd equals incoming rs1 (all used types) or rs2 (R, store, branch only). Then in_ready=0 and a bubble is written to ID/EX; the instruction stays at IF/ID and is retried.
- in_ready = !hazard. Capture occurs when in_valid && in_ready && !flush.
- Bubble: out_valid=0 and all control outputs 0; rs/rd/imm/pc/funct fields don't-care but driven 0.

## Timing
- Reset (async): out_valid=0, all control outputs 0, ALUop=00, funct7/funct3/rs1/rs2/rd=0, imm=0, pc_out=0. in_ready=1 once reset deasserts (no registered load).
- Latency: one cycle, instr at edge N appears on outputs after edge N.
- Per edge priority: flush > hazard > capture > idle. Flush loads a bubble regardless of in_valid or hazard; in_ready is not forced low by flush.
- in_valid=0 without flush or hazard loads a bubble.
- Hazard lasts exactly one cycle per load: after the bubble, MemRead in ID/EX is 0, so the retry is accepted next cycle.
- in_ready is combinational from ID/EX state and instr; no combinational path from flush to in_ready.
- Reset asserted mid-stall: outputs clear immediately, and the stall releases.

## Configuration
- ID_ILLEGAL_TRAP_EN defined: adds output illegal (1 bit, reset 0). It is registered high for one cycle with out_valid=0 when an unsupported opcode is accepted. Also flagged: R-type funct7 not in {0000000,0100000}, and I-ALU funct3=001 with funct7!=0000000.
- Undefined: the port is absent. Unsupported encodings silently become bubbles.

## Test plan
- Reset: assert reset mid-cycle with a valid add in flight -> all outputs 0 asynchronously, out_valid=0.
- ADD x3,x1,x2 (0x002081B3) -> next cycle ALUop=10, funct7=0, funct3=0, RegWrite=1, rd=3, out_valid=1. SUB (0x402081B3) -> funct7=0100000.
- ADDI x5,x0,-1 (0xFFF00293) -> ALUop=10, ALUSrc=1, funct7=0000000, imm=0xFFFF_FFFF_FFFF_FFFF. SRAI x5,x5,3 (0x4032D293) -> funct7=0100000.
- LD x6,8(x1) followed by ADD x7,x6,x2 -> cycle 2 in_ready=0 and bubble out. Cycle 3 accepts the add. Repeat with rd=x0 -> no stall.
- BEQ x1,x2,-4 (0xFE208EE3) -> ALUop=01, Branch=1, imm=-4. Flush asserted in the same cycle as the valid SD -> bubble out, no MemWrite.
- Opcode 0x7F with and without ID_ILLEGAL_TRAP_EN -> bubble. illegal=1 for one cycle only when defined.

Source files
------------

// File: rtl/id_control_stage.sv
// Instruction-decode control stage: opcode decode, immediate generation, load-use stall and flush into ID/EX.
// Optional ID_ILLEGAL_TRAP_EN adds a one-cycle 'illegal' flag for unsupported encodings.
module id_control_stage #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc_in,
   input  logic            flush,
   output logic            out_valid,
   output logic [1:0]      ALUop,
   output logic [6:0]      funct7,
   output logic [2:0]      funct3,
   output logic            ALUSrc,
   output logic            MemRead,
   output logic            MemWrite,
   output logic            MemtoReg,
   output logic            RegWrite,
   output logic            Branch,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [XLEN-1:0] imm,
   output logic [XLEN-1:0] pc_out
`ifdef ID_ILLEGAL_TRAP_EN
   ,
   output logic            illegal
`endif
);

   typedef struct packed {
      logic            valid;
      logic [1:0]      aluop;
      logic [6:0]      f7;
      logic [2:0]      f3;
      logic            alusrc;
      logic            mem_read;
      logic            mem_write;
      logic            mem_to_reg;
      logic            reg_write;
      logic            branch;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
   } idex_t;

   idex_t st_d, st_q, dec;

   logic [6:0]      opcode;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [4:0]      src1, src2;
   logic            is_r, is_i, is_ld, is_st, is_br;
   logic            use_rs2, legal, hazard, accept;
   logic [XLEN-1:0] imm_i, imm_s, imm_b;

   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign f7     = instr[31:25];
   assign src1   = instr[19:15];
   assign src2   = instr[24:20];

   assign is_r  = (opcode == 7'b0110011);
   assign is_i  = (opcode == 7'b0010011);
   assign is_ld = (opcode == 7'b0000011);
   assign is_st = (opcode == 7'b0100011);
   assign is_br = (opcode == 7'b1100011);

   assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
   assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                   instr[30:25], instr[11:8], 1'b0};

   assign use_rs2 = is_r | is_st | is_br;

`ifdef ID_ILLEGAL_TRAP_EN
   logic bad_enc;
   logic illegal_d, illegal_q;

   assign bad_enc = (is_r && f7 != 7'b0000000 && f7 != 7'b0100000)
                  | (is_i && f3 == 3'b001 && f7 != 7'b0000000);
   assign legal   = (is_r | is_i | is_ld | is_st | is_br) & ~bad_enc;
`else
   assign legal   = is_r | is_i | is_ld | is_st | is_br;
`endif

   // Stall only on a real load whose destination feeds a source this instr reads
   always_comb begin
      hazard = 1'b0;
      if (st_q.valid && st_q.mem_read && st_q.rd != 5'd0) begin
         if ((is_r | is_i | is_ld | is_st | is_br) && st_q.rd == src1)
            hazard = 1'b1;
         if (use_rs2 && st_q.rd == src2)
            hazard = 1'b1;
      end
   end

   assign in_ready = ~hazard;
   assign accept   = in_valid & ~hazard & ~flush;

   always_comb begin
      dec     = '0;
      dec.f3  = f3;
      dec.f7  = f7;
      dec.rs1 = src1;
      dec.pc  = pc_in;
      unique case (1'b1)
         is_r: begin
            dec.aluop     = 2'b10;
            dec.reg_write = 1'b1;
            dec.rs2       = src2;
            dec.rd        = instr[11:7];
         end
         is_i: begin
            dec.aluop     = 2'b10;
            dec.alusrc    = 1'b1;
            dec.reg_write = 1'b1;
            dec.rd        = instr[11:7];
            dec.imm       = imm_i;
            if (f3 != 3'b101)
               dec.f7 = 7'b0000000;
         end
         is_ld: begin
            dec.alusrc     = 1'b1;
            dec.mem_read   = 1'b1;
            dec.mem_to_reg = 1'b1;
            dec.reg_write  = 1'b1;
            dec.rd         = instr[11:7];
            dec.imm        = imm_i;
         end
         is_st: begin
            dec.alusrc    = 1'b1;
            dec.mem_write = 1'b1;
            dec.rs2       = src2;
            dec.imm       = imm_s;
         end
         is_br: begin
            dec.aluop  = 2'b01;
            dec.branch = 1'b1;
            dec.rs2    = src2;
            dec.imm    = imm_b;
         end
         default: ;
      endcase
      dec.valid = 1'b1;
   end

   always_comb begin
      st_d = '0;
      if (accept && legal)
         st_d = dec;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         st_q <= '0;
      else
         st_q <= st_d;
   end

`ifdef ID_ILLEGAL_TRAP_EN
   assign illegal_d = accept & ~legal;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         illegal_q <= 1'b0;
      else
         illegal_q <= illegal_d;
   end

   assign illegal = illegal_q;
`endif

   assign out_valid = st_q.valid;
   assign ALUop     = st_q.aluop;
   assign funct7    = st_q.f7;
   assign funct3    = st_q.f3;
   assign ALUSrc    = st_q.alusrc;
   assign MemRead   = st_q.mem_read;
   assign MemWrite  = st_q.mem_write;
   assign MemtoReg  = st_q.mem_to_reg;
   assign RegWrite  = st_q.reg_write;
   assign Branch    = st_q.branch;
   assign rs1       = st_q.rs1;
   assign rs2       = st_q.rs2;
   assign rd        = st_q.rd;
   assign imm       = st_q.imm;
   assign pc_out    = st_q.pc;

endmodule

// File: tb/tb_id_control_stage.sv
// Scoreboard bench for id_control_stage: driver queues expected ID/EX contents,
// a monitor compares them one edge later; reset and stall cases are checked inline.
module tb_id_control_stage;

   typedef struct packed {
      logic        v;
      logic [1:0]  aop;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic [5:0]  c;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [4:0]  rd;
      logic [63:0] imm;
      logic [63:0] pc;
   } exp_t;

   localparam logic [5:0] CR  = 6'b000010;
   localparam logic [5:0] CI  = 6'b100010;
   localparam logic [5:0] CLD = 6'b110110;
   localparam logic [5:0] CST = 6'b101000;
   localparam logic [5:0] CBR = 6'b000001;
   localparam exp_t       BUB = '0;

   localparam logic [31:0] ADD   = 32'h002081B3;
   localparam logic [31:0] SUB   = 32'h402081B3;
   localparam logic [31:0] ADDI  = 32'hFFF00293;
   localparam logic [31:0] SRAI  = 32'h4032D293;
   localparam logic [31:0] LD6   = 32'h0080B303;
   localparam logic [31:0] LD0   = 32'h0080B003;
   localparam logic [31:0] ADD76 = 32'h002303B3;
   localparam logic [31:0] ADD70 = 32'h002003B3;
   localparam logic [31:0] ADDI7 = 32'h00608393;
   localparam logic [31:0] BEQ   = 32'hFE208EE3;
   localparam logic [31:0] SD    = 32'h0020B823;
   localparam logic [31:0] BAD   = 32'h0000007F;

   logic        clk, reset, in_valid, in_ready, flush;
   logic [31:0] instr;
   logic [63:0] pc_in, imm, pc_out;
   logic        out_valid, ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite, Branch;
   logic [1:0]  ALUop;
   logic [6:0]  funct7;
   logic [2:0]  funct3;
   logic [4:0]  rs1, rs2, rd;
`ifdef ID_ILLEGAL_TRAP_EN
   logic        illegal;
`endif

   int checks = 0;
   int fails  = 0;
   exp_t  q[$];
   string nq[$];
   exp_t  mon_e;
   string mon_n;

   id_control_stage #(.XLEN(64)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .pc_in(pc_in), .flush(flush), .out_valid(out_valid),
      .ALUop(ALUop), .funct7(funct7), .funct3(funct3), .ALUSrc(ALUSrc),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
      .RegWrite(RegWrite), .Branch(Branch), .rs1(rs1), .rs2(rs2), .rd(rd),
      .imm(imm), .pc_out(pc_out)
`ifdef ID_ILLEGAL_TRAP_EN
      , .illegal(illegal)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t act();
      act = {out_valid, ALUop, funct7, funct3, ALUSrc, MemRead, MemWrite,
             MemtoReg, RegWrite, Branch, rs1, rs2, rd, imm, pc_out};
   endfunction

   function automatic exp_t mk(input logic [1:0] aop, input logic [6:0] f7,
                               input logic [2:0] f3, input logic [5:0] c,
                               input logic [4:0] r1, input logic [4:0] r2,
                               input logic [4:0] d, input logic [63:0] im,
                               input logic [63:0] pc);
      mk = {1'b1, aop, f7, f3, c, r1, r2, d, im, pc};
   endfunction

   task automatic chk_out(input string nm, input exp_t e);
      checks++;
      if (act() !== e) begin
         fails++;
         $display("FAIL %s got %h want %h", nm, act(), e);
      end
   endtask

   task automatic chk_rdy(input string nm, input logic want);
      checks++;
      if (in_ready !== want) begin
         fails++;
         $display("FAIL %s in_ready got %b want %b", nm, in_ready, want);
      end
   endtask

   task automatic step(input logic iv, input logic [31:0] ins,
                       input logic [63:0] pc, input logic fl,
                       input logic rdy, input exp_t e, input string nm);
      @(negedge clk);
      in_valid = iv;
      instr    = ins;
      pc_in    = pc;
      flush    = fl;
      #1;
      chk_rdy(nm, rdy);
      q.push_back(e);
      nq.push_back(nm);
      @(posedge clk);
   endtask

   always @(posedge clk) begin
      #1;
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         mon_n = nq.pop_front();
         chk_out(mon_n, mon_e);
      end
   end

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      flush    = 1'b0;
      instr    = '0;
      pc_in    = '0;
      #12;
      chk_out("reset_init", BUB);
      chk_rdy("reset_init", 1'b1);
      @(negedge clk);
      reset = 1'b0;

      step(1, ADD,   64'h1000, 0, 1, mk(2'b10, 7'h00, 3'd0, CR, 5'd1, 5'd2, 5'd3, 64'd0, 64'h1000), "add");
      step(1, SUB,   64'h1004, 0, 1, mk(2'b10, 7'h20, 3'd0, CR, 5'd1, 5'd2, 5'd3, 64'd0, 64'h1004), "sub");
      step(1, ADDI,  64'h1008, 0, 1, mk(2'b10, 7'h00, 3'd0, CI, 5'd0, 5'd0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1008), "addi_m1");
      step(1, SRAI,  64'h100C, 0, 1, mk(2'b10, 7'h20, 3'd5, CI, 5'd5, 5'd0, 5'd5, 64'h403, 64'h100C), "srai");
      step(1, LD6,   64'h1010, 0, 1, mk(2'b00, 7'h00, 3'd3, CLD, 5'd1, 5'd0, 5'd6, 64'd8, 64'h1010), "ld_x6");
      step(1, ADD76, 64'h1014, 0, 0, BUB, "loaduse_stall");
      step(1, ADD76, 64'h1014, 0, 1, mk(2'b10, 7'h00, 3'd0, CR, 5'd6, 5'd2, 5'd7, 64'd0, 64'h1014), "loaduse_retry");
      step(1, LD0,   64'h1018, 0, 1, mk(2'b00, 7'h00, 3'd3, CLD, 5'd1, 5'd0, 5'd0, 64'd8, 64'h1018), "ld_x0");
      step(1, ADD70, 64'h101C, 0, 1, mk(2'b10, 7'h00, 3'd0, CR, 5'd0, 5'd2, 5'd7, 64'd0, 64'h101C), "x0_nostall");
      step(1, LD6,   64'h1020, 0, 1, mk(2'b00, 7'h00, 3'd3, CLD, 5'd1, 5'd0, 5'd6, 64'd8, 64'h1020), "ld_x6_b");
      step(1, ADDI7, 64'h1024, 0, 1, mk(2'b10, 7'h00, 3'd0, CI, 5'd1, 5'd0, 5'd7, 64'd6, 64'h1024), "irs2_nostall");
      step(1, BEQ,   64'h1028, 0, 1, mk(2'b01, 7'h7F, 3'd0, CBR, 5'd1, 5'd2, 5'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1028), "beq");
      step(1, SD,    64'h102C, 1, 1, BUB, "sd_flush");
      step(1, SD,    64'h102C, 0, 1, mk(2'b00, 7'h00, 3'd3, CST, 5'd1, 5'd2, 5'd0, 64'd16, 64'h102C), "sd");
      step(1, LD6,   64'h1030, 0, 1, mk(2'b00, 7'h00, 3'd3, CLD, 5'd1, 5'd0, 5'd6, 64'd8, 64'h1030), "ld_x6_c");
      step(1, ADD76, 64'h1034, 1, 0, BUB, "flush_in_stall");
      step(1, ADD76, 64'h1034, 0, 1, mk(2'b10, 7'h00, 3'd0, CR, 5'd6, 5'd2, 5'd7, 64'd0, 64'h1034), "after_flush");
      step(0, ADD,   64'h1038, 0, 1, BUB, "invalid_in");
      step(1, BAD,   64'h103C, 0, 1, BUB, "bad_opcode");
`ifdef ID_ILLEGAL_TRAP_EN
      #1;
      checks++;
      if (illegal !== 1'b1) begin
         fails++;
         $display("FAIL illegal_set got %b want 1", illegal);
      end
`endif
      step(0, 32'd0, 64'h0, 0, 1, BUB, "idle");
`ifdef ID_ILLEGAL_TRAP_EN
      #1;
      checks++;
      if (illegal !== 1'b0) begin
         fails++;
         $display("FAIL illegal_clear got %b want 0", illegal);
      end
`endif

      step(1, LD6, 64'h1040, 0, 1, mk(2'b00, 7'h00, 3'd3, CLD, 5'd1, 5'd0, 5'd6, 64'd8, 64'h1040), "ld_pre_rst");
      @(negedge clk);
      in_valid = 1'b1;
      instr    = ADD76;
      pc_in    = 64'h1044;
      #1;
      chk_rdy("stall_pre_rst", 1'b0);
      #1;
      reset = 1'b1;
      #1;
      chk_out("rst_mid_stall", BUB);
      chk_rdy("rst_mid_stall", 1'b1);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      step(1, ADD, 64'h1050, 0, 1, mk(2'b10, 7'h00, 3'd0, CR, 5'd1, 5'd2, 5'd3, 64'd0, 64'h1050), "add_pre_rst");
      @(negedge clk);
      in_valid = 1'b1;
      instr    = ADD;
      pc_in    = 64'h1054;
      #2;
      reset = 1'b1;
      #1;
      chk_out("rst_mid_add", BUB);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      step(1, ADD, 64'h1058, 0, 1, mk(2'b10, 7'h00, 3'd0, CR, 5'd1, 5'd2, 5'd3, 64'd0, 64'h1058), "add_post_rst");

      for (int i = 0; i < 5 && q.size() > 0; i++)
         @(posedge clk);
      #2;
      if (q.size() > 0) begin
         fails++;
         $display("FAIL drain pending %0d want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", checks, fails);
      $finish;
   end

endmodule
